// File: rtl/mem_stage_dmem_if.sv
// Memory-stage request/response bundle between the EX/MEM register (master)
// and the wait-stated data memory (slave).
interface mem_stage_dmem_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Address_i;
  logic [31:0] Write_data_i;
  logic [31:0] Read_data_o;
  logic        stall_o;
  logic        done_o;
  logic        misalign_o;

  modport master (
    output MemRead_i, MemWrite_i, Address_i, Write_data_i,
    input  Read_data_o, stall_o, done_o, misalign_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, Address_i, Write_data_i,
    output Read_data_o, stall_o, done_o, misalign_o
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// Wait-stated data memory for the MEM stage: stalls the pipeline LATENCY cycles
// per access, then commits the write or returns registered read data.
module mem_stage_dmem #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_stage_dmem_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_write;
  logic            op_read;
  logic            op_misalign;
  logic [AW-1:0]   op_idx;
  logic [31:0]     op_wdata;
  logic [31:0]     read_q;
  logic            done_q;
  logic            misalign_q;

  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            req_misalign;
  logic [AW-1:0]   req_idx;
  logic            fire;
  logic            acc_write;
  logic            acc_read;
  logic            acc_misalign;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            unused_addr;

  assign req          = bus.MemRead_i | bus.MemWrite_i;
  assign req_idx      = bus.Address_i[AW+1:2];
  assign req_misalign = (bus.Address_i[1:0] != 2'b00);
  assign unused_addr  = ^bus.Address_i[31:AW+2];

  // The access uses the live request when LATENCY==1 (it commits on the
  // request edge itself), otherwise the operands latched in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    acc_write    = op_write;
    acc_read     = op_read;
    acc_misalign = op_misalign;
    acc_idx      = op_idx;
    acc_wdata    = op_wdata;
    fire         = 1'b0;
    if (state == IDLE) begin
      acc_write    = bus.MemWrite_i;
      acc_read     = bus.MemRead_i & ~bus.MemWrite_i;
      acc_misalign = req_misalign;
      acc_idx      = req_idx;
      acc_wdata    = bus.Write_data_i;
      fire         = req && (LATENCY == 1);
    end else if (state == BUSY) begin
      fire = (cnt == CW'(1));
    end
  end

  assign bus.stall_o     = ((state == IDLE) && req && !rst_i) || (state == BUSY);
  assign bus.done_o      = done_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.Read_data_o = read_q;

  // cnt holds the stall cycles still owed after the request cycle, so the
  // access fires in the last BUSY cycle and DONE lands in cycle LATENCY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      read_q      <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      op_write    <= 1'b0;
      op_read     <= 1'b0;
      op_misalign <= 1'b0;
      op_idx      <= '0;
      op_wdata    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write    <= acc_write;
            op_read     <= acc_read;
            op_misalign <= acc_misalign;
            op_idx      <= acc_idx;
            op_wdata    <= acc_wdata;
            cnt         <= CW'(LATENCY - 1);
            if (LATENCY > 1) state <= BUSY;
          end
        end
        BUSY:    cnt   <= cnt - CW'(1);
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        if (acc_read) read_q <= acc_misalign ? 32'h0 : mem[acc_idx];
        done_q     <= 1'b1;
        misalign_q <= acc_misalign;
        state      <= DONE;
      end
    end
  end

  // NOTE: the storage array has no reset; only the control path is reset, and
  // a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fire && acc_write && !acc_misalign) mem[acc_idx] <= acc_wdata;
  end

endmodule
